mux2_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select of a 2:1 mux and registers the selected data. Each requester raises `req0`/`req1` and holds it for as long as it needs the shared path. The arbiter grants one requester at a time, drives `sel`, and presents the granted input on a registered output `y` with a valid flag. It sits in front of any shared single-lane datapath in the combinational library, replacing a testbench- or software-driven `sel`.

---
 rtl/mux2_arb_pkg.sv | 18 +
 rtl/mux2.sv | 11 +
 rtl/mux2_arbiter.sv | 134 +++++++++++++
 tb/tb_mux2_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    // Last-served index out of reset; 1 lets requester 0 win the first tie.
    localparam logic LAST_RST = 1'b1;

    // Tie winner is whichever requester was not served most recently.
    function automatic arb_state_e tie_winner(input logic last);
        return last ? OWN0 : OWN1;
    endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 mux cell; s=0 passes a, s=1 passes b.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning a 2:1 mux select, with a registered data output.
// Optional forced handoff after MAX_HOLD grant cycles when MUX2_ARB_TIMEOUT_EN is defined.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    arb_state_e       state;
    arb_state_e       state_d;
    logic             last;
    logic             last_d;
    logic             sel_d;
    logic             hold_expired;
    logic [WIDTH-1:0] mux_y;

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("mux2_arbiter: MAX_HOLD must be at least 2");
    end

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;

    // Saturates at MAX_HOLD-1 so an uncontested owner keeps the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_d != state) begin
            hold_cnt <= '0;
        end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = tie_winner(last);
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && hold_expired) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && hold_expired) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the select and last-served index keep their previous values.
    always_comb begin
        last_d = last;
        sel_d  = sel;
        if (state_d == OWN0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= LAST_RST;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= state_d;
            last  <= last_d;
            gnt0  <= (state_d == OWN0);
            gnt1  <= (state_d == OWN1);
            sel   <= sel_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2 u_mux2 (
            .a(d0[i]),
            .b(d1[i]),
            .s(sel),
            .y(mux_y[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y       <= mux_y;
            y_valid <= gnt0 | gnt1;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed vectors push expectations, a monitor pops them.
`timescale 1ns/1ps
module tb_mux2_arbiter;

    localparam int WIDTH = 4;

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    // Expected vector layout: {gnt0, gnt1, sel, y_valid, y}
    typedef struct {
        logic [7:0] v;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(
        .WIDTH(WIDTH),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0(req0),
        .req1(req1),
        .d0(d0),
        .d1(d1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .sel(sel),
        .y(y),
        .y_valid(y_valid)
    );

    // ctl = {rst_n, req0, req1}; flags = {gnt0, gnt1, sel, y_valid}
    task automatic step(input logic [2:0] ctl, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] flags, input logic [3:0] ey, input string nm,
                        input bit rst_mid = 1'b0);
        exp_t item;
        @(negedge clk);
        #1;
        rst_n = ctl[2];
        req0  = ctl[1];
        req1  = ctl[0];
        d0    = a;
        d1    = b;
        item.v    = {flags, ey};
        item.name = nm;
        sb_q.push_back(item);
        if (rst_mid) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t       it;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                got = {gnt0, gnt1, sel, y_valid, y};
                checks++;
                if (got !== it.v) begin
                    fails++;
                    $display("FAIL %s: got g0,g1,sel,yv=%b y=%h, expected g0,g1,sel,yv=%b y=%h",
                             it.name, got[7:4], got[3:0], it.v[7:4], it.v[3:0]);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        d0    = '0;
        d1    = '0;

        step(3'b000, 4'h0, 4'h0, 4'b0000, 4'h0, "reset");
        step(3'b100, 4'h5, 4'hA, 4'b0000, 4'h5, "idle_start");
        // single requester
        step(3'b110, 4'h5, 4'hA, 4'b1000, 4'h5, "single_gnt");
        step(3'b110, 4'h5, 4'hA, 4'b1001, 4'h5, "single_data");
        step(3'b100, 4'h5, 4'hA, 4'b0001, 4'h5, "single_drop");
        step(3'b100, 4'h5, 4'hA, 4'b0000, 4'h5, "single_vfall");
        // tie alternation, last served = 0
        step(3'b111, 4'h5, 4'hA, 4'b0110, 4'h5, "tie1");
        step(3'b100, 4'h5, 4'hA, 4'b0011, 4'hA, "tie1_rel");
        step(3'b111, 4'h5, 4'hA, 4'b1000, 4'hA, "tie2");
        step(3'b100, 4'h5, 4'hA, 4'b0001, 4'h5, "tie2_rel");
        step(3'b111, 4'h5, 4'hA, 4'b0110, 4'h5, "tie3");
        step(3'b100, 4'h5, 4'hA, 4'b0011, 4'hA, "tie3_rel");
        step(3'b111, 4'h5, 4'hA, 4'b1000, 4'hA, "tie4");
        // direct handoff from OWN0
        step(3'b111, 4'h0, 4'hF, 4'b1001, 4'h0, "hand_pre");
        step(3'b101, 4'h0, 4'hF, 4'b0111, 4'h0, "handoff");
        step(3'b101, 4'h0, 4'hF, 4'b0111, 4'hF, "hand_data");
        // idle hold after OWN1
        step(3'b100, 4'h0, 4'hF, 4'b0011, 4'hF, "idle_rel");
        step(3'b100, 4'h0, 4'h3, 4'b0010, 4'h3, "idle_track");
        step(3'b100, 4'h0, 4'hC, 4'b0010, 4'hC, "idle_track2");
        // timeout: req0 held, req1 joins one cycle later
        step(3'b110, 4'h5, 4'hA, 4'b1000, 4'hA, "to_gnt");
        step(3'b111, 4'h5, 4'hA, 4'b1001, 4'h5, "to_hold1");
        step(3'b111, 4'h5, 4'hA, 4'b1001, 4'h5, "to_hold2");
        step(3'b111, 4'h5, 4'hA, 4'b1001, 4'h5, "to_hold3");
        step(3'b111, 4'h5, 4'hA, TO ? 4'b0111 : 4'b1001, 4'h5, "to_handoff");
        step(3'b111, 4'h5, 4'hA, TO ? 4'b0111 : 4'b1001, TO ? 4'hA : 4'h5, "to_after");
        // uncontested owner: counter must saturate, not wrap
        step(3'b101, 4'hA, 4'hA, 4'b0111, 4'hA, "sat_start");
        step(3'b101, 4'h5, 4'hA, 4'b0111, 4'hA, "sat_1");
        step(3'b101, 4'h5, 4'hA, 4'b0111, 4'hA, "sat_2");
        step(3'b101, 4'h5, 4'hA, 4'b0111, 4'hA, "sat_3");
        step(3'b111, 4'h5, 4'hA, TO ? 4'b1001 : 4'b0111, 4'hA, "sat_preempt");
        step(3'b101, 4'hA, 4'hA, 4'b0111, 4'hA, "pre_rst");
        // asynchronous reset while OWN1 holds y=A
        step(3'b101, 4'hA, 4'hA, 4'b0000, 4'h0, "rst_async", 1'b1);
        step(3'b011, 4'h5, 4'hA, 4'b0000, 4'h0, "rst_hold");
        step(3'b111, 4'h5, 4'hA, 4'b1000, 4'h5, "rst_tie");
        step(3'b111, 4'h5, 4'hA, 4'b1001, 4'h5, "rst_data");

        @(negedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
